// File: rtl/gcd_binary_core_if.sv
// Handshake bundle for gcd_binary_core.
// Operand side:  in_valid/in_ready with a, b (unsigned, WIDTH bits).
// Result side:   out_valid/out_ready with result (WIDTH) and cycles (CNT_W).
// master: producer/consumer environment; slave: the GCD core.
interface gcd_binary_core_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [CNT_W-1:0] cycles;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, cycles
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, cycles
  );
endinterface

// File: rtl/gcd_binary_core.sv
// Binary (Stein) GCD engine, one shift/subtract step per clock.
// Ports:
//   clk   - single clock, rising edge
//   reset - asynchronous, active-low
//   bus   - gcd_binary_core_if.slave: operand handshake (in_valid/in_ready, a, b)
//           and result handshake (out_valid/out_ready, result, cycles)
// All handshake outputs are registered.
module gcd_binary_core #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  gcd_binary_core_if.slave bus
);

  localparam int unsigned K_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_x,         w_x_nxt;
  logic [WIDTH-1:0] r_y,         w_y_nxt;
  logic [K_W-1:0]   r_k,         w_k_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic [WIDTH-1:0] r_result,    w_result_nxt;
  logic [CNT_W-1:0] r_cycles,    w_cycles_nxt;
  logic             r_in_ready,  w_in_ready_nxt;
  logic             r_out_valid, w_out_valid_nxt;

  logic             w_accept;
  logic [CNT_W-1:0] w_cnt_sat;
  logic [WIDTH-1:0] w_diff_xy;
  logic [WIDTH-1:0] w_diff_yx;

  assign w_accept  = bus.in_valid && r_in_ready;
  assign w_cnt_sat = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_diff_xy = r_x - r_y;
  assign w_diff_yx = r_y - r_x;

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_x         <= '0;
      r_y         <= '0;
      r_k         <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_cycles    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_k         <= w_k_nxt;
      r_cnt       <= w_cnt_nxt;
      r_result    <= w_result_nxt;
      r_cycles    <= w_cycles_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_k_nxt         = r_k;
    w_cnt_nxt       = r_cnt;
    w_result_nxt    = r_result;
    w_cycles_nxt    = r_cycles;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;

    case (r_state)
      S_IDLE: begin
        // in_ready comes up on the first edge after reset release
        w_in_ready_nxt = 1'b1;
        if (w_accept) begin
          w_in_ready_nxt = 1'b0;
          if ((bus.a == '0) || (bus.b == '0)) begin
            // out_valid is raised by DONE one cycle later, giving a one-cycle latency
            w_result_nxt = bus.a | bus.b;
            w_cycles_nxt = '0;
            w_state_nxt  = S_DONE;
          end else begin
            w_x_nxt     = bus.a;
            w_y_nxt     = bus.b;
            w_k_nxt     = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = S_RUN;
          end
        end
      end

      S_RUN: begin
        w_cnt_nxt = w_cnt_sat;
        if (r_x == r_y) begin
          w_result_nxt    = r_x << r_k;
          w_cycles_nxt    = w_cnt_sat;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = S_DONE;
        end else if (!r_x[0] && !r_y[0]) begin
          w_x_nxt = r_x >> 1;
          w_y_nxt = r_y >> 1;
          w_k_nxt = r_k + K_W'(1);
        end else if (!r_x[0]) begin
          w_x_nxt = r_x >> 1;
        end else if (!r_y[0]) begin
          w_y_nxt = r_y >> 1;
        end else if (r_x > r_y) begin
          // odd minus odd is even, so the halving is exact
          w_x_nxt = w_diff_xy >> 1;
        end else begin
          w_y_nxt = w_diff_yx >> 1;
        end
      end

      S_DONE: begin
        if (!r_out_valid) begin
          w_out_valid_nxt = 1'b1;
        end else if (bus.out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end

      default: begin
        w_state_nxt     = S_IDLE;
        w_in_ready_nxt  = 1'b0;
        w_out_valid_nxt = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.cycles    = r_cycles;

endmodule

// File: tb/tb_gcd_binary_core.sv
// Directed bench for gcd_binary_core (WIDTH=32, CNT_W=8).
// Expected results go into a scoreboard queue when an operand pair is driven
// and are popped when the core presents its result.
module tb_gcd_binary_core;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 8;

  typedef struct {
    logic [WIDTH-1:0] res;
    int               cyc;  // -1: only the 2*WIDTH+1 bound applies
    int               lat;  // -1: not checked
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  gcd_binary_core_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  gcd_binary_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Euclid by remainder, independent of the shift/subtract method under test
  function automatic logic [WIDTH-1:0] gcd_ref(input logic [WIDTH-1:0] p_in, input logic [WIDTH-1:0] q_in);
    logic [WIDTH-1:0] p, q, t;
    p = p_in;
    q = q_in;
    while (q != '0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic wait_ready(input string tag);
    int waited = 0;
    while (bus.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  task automatic do_op(input string tag, input logic [WIDTH-1:0] oa, input logic [WIDTH-1:0] ob,
                       input int exp_lat, input int exp_cyc, input int stall);
    exp_t e;
    int   lat;
    e.res = gcd_ref(oa, ob);
    e.cyc = exp_cyc;
    e.lat = exp_lat;
    sb.push_back(e);

    wait_ready(tag);
    bus.in_valid  = 1'b1;
    bus.a         = oa;
    bus.b         = ob;
    bus.out_ready = (stall == 0);
    @(posedge clk);
    @(negedge clk);
    // operands are latched; scramble them to prove it
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;

    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_busy_in_ready"}, 64'(bus.in_ready), 64'd0);

    e = sb.pop_front();
    check({tag, "_result"}, 64'(bus.result), 64'(e.res));
    if (e.cyc >= 0) check({tag, "_cycles"}, 64'(bus.cycles), 64'(e.cyc));
    else            check({tag, "_cycles_bound"}, 64'(bus.cycles <= CNT_W'(2*WIDTH+1)), 64'd1);
    if (e.lat >= 0) check({tag, "_latency"}, 64'(lat), 64'(e.lat));

    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check($sformatf("%s_hold%0d_result", tag, i), 64'(bus.result), 64'(e.res));
      check($sformatf("%s_hold%0d_valid", tag, i), 64'(bus.out_valid), 64'd1);
      check($sformatf("%s_hold%0d_in_ready", tag, i), 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_handoff_valid"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_handoff_in_ready"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    int rise;
    logic [WIDTH-1:0] ra, rb;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;

    // reset held for 4 cycles, outputs all zero
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rst%0d_outs", i),
            {30'd0, bus.in_ready, bus.out_valid, bus.result}, 64'd0);
      check($sformatf("rst%0d_cycles", i), 64'(bus.cycles), 64'd0);
    end
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_before_edge", 64'(bus.in_ready), 64'd0);
    @(negedge clk);
    check("rel_in_ready_after_edge", 64'(bus.in_ready), 64'd1);

    do_op("g36_9",   32'd36,   32'd9,    3,  3,  0);
    do_op("g48_18",  32'd48,   32'd18,   6,  6,  0);
    do_op("g17_5",   32'd17,   32'd5,    5,  5,  0);
    do_op("z0_7",    32'd0,    32'd7,    1,  0,  0);
    do_op("z7_0",    32'd7,    32'd0,    1,  0,  0);
    do_op("z0_0",    32'd0,    32'd0,    1,  0,  0);
    do_op("bp1024",  32'd1024, 32'd4096, 13, 13, 10);
    do_op("ext_max", 32'hFFFF_FFFF, 32'd1, 32, 32, 0);
    do_op("ext_msb", 32'h8000_0000, 32'h8000_0000, 1, 1, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 24);
      do_op($sformatf("rnd%0d", i), ra, rb, -1, -1, i % 3);
    end

    // reset in the middle of a run: result must never appear
    wait_ready("abort");
    bus.in_valid = 1'b1;
    bus.a        = 32'd48;
    bus.b        = 32'd18;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_valid_in_reset", 64'(bus.out_valid), 64'd0);
    check("abort_ready_in_reset", 64'(bus.in_ready), 64'd0);
    check("abort_result_in_reset", 64'(bus.result), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rise = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) rise++;
    end
    check("abort_no_valid", 64'(rise), 64'd0);
    check("abort_idle_ready", 64'(bus.in_ready), 64'd1);

    do_op("post_abort", 32'd36, 32'd9, 3, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
